// File: rtl/clock_pkg.sv
// Shared types and constants for the digital clock time-setting controller.
// Digit positions follow the 8-digit scanner order: hh, sep, mm, sep, ss.
package clock_pkg;

    typedef enum logic [2:0] {
        RUN,
        SET_HH,
        SET_MM,
        SET_SS,
        COMMIT
    } state_t;

    typedef enum logic [1:0] {
        FIELD_HH   = 2'd0,
        FIELD_MM   = 2'd1,
        FIELD_SS   = 2'd2,
        FIELD_NONE = 2'd3
    } field_t;

    localparam int KEY_MODE = 0;
    localparam int KEY_NEXT = 1;
    localparam int KEY_UP   = 2;
    localparam int KEY_DOWN = 3;

    localparam int HH_MAX = 23;
    localparam int MS_MAX = 59;

    localparam int DIG_HH_HI = 0;
    localparam int DIG_HH_LO = 1;
    localparam int DIG_MM_HI = 3;
    localparam int DIG_MM_LO = 4;
    localparam int DIG_SS_HI = 6;
    localparam int DIG_SS_LO = 7;

    function automatic logic [7:0] field_mask(input field_t f);
        logic [7:0] m;
        m = '0;
        case (f)
            FIELD_HH: begin
                m[DIG_HH_HI] = 1'b1;
                m[DIG_HH_LO] = 1'b1;
            end
            FIELD_MM: begin
                m[DIG_MM_HI] = 1'b1;
                m[DIG_MM_LO] = 1'b1;
            end
            FIELD_SS: begin
                m[DIG_SS_HI] = 1'b1;
                m[DIG_SS_LO] = 1'b1;
            end
            default: m = '0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/key_repeat.sv
// Rising-edge detector with typematic auto-repeat for one debounced key.
// Emits a step on the press, again after the hold time, then at the repeat period.
module key_repeat #(
    parameter int F_CLK     = 50000000,
    parameter int HOLD_MS   = 500,
    parameter int REPEAT_MS = 100
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key,
    output logic step
);

    localparam int HOLD_CYC   = HOLD_MS * (F_CLK / 1000);
    localparam int REPEAT_CYC = REPEAT_MS * (F_CLK / 1000);
    localparam int MAX_CYC    = (HOLD_CYC > REPEAT_CYC) ? HOLD_CYC : REPEAT_CYC;
    localparam int CNT_W      = $clog2(MAX_CYC + 1);

    localparam logic [CNT_W-1:0] HOLD_LIM   = CNT_W'(HOLD_CYC);
    localparam logic [CNT_W-1:0] REPEAT_LIM = CNT_W'(REPEAT_CYC);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    logic             key_prev;
    logic             repeating;
    logic [CNT_W-1:0] cnt;
    logic             press;
    logic             hold_hit;

    // cnt holds the cycles elapsed since the press (or since the last repeat step)
    assign press    = key & ~key_prev;
    assign hold_hit = key & key_prev & (cnt == (repeating ? REPEAT_LIM : HOLD_LIM));
    assign step     = press | hold_hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_prev  <= 1'b0;
            repeating <= 1'b0;
            cnt       <= '0;
        end else begin
            key_prev <= key;
            if (!key) begin
                repeating <= 1'b0;
                cnt       <= '0;
            end else if (press) begin
                repeating <= 1'b0;
                cnt       <= CNT_ONE;
            end else if (hold_hit) begin
                repeating <= 1'b1;
                cnt       <= CNT_ONE;
            end else begin
                cnt <= cnt + CNT_ONE;
            end
        end
    end

endmodule

// File: rtl/clock_set_ctrl.sv
// Key-driven time-setting controller: freezes the timekeeper, edits hh/mm/ss,
// writes the result back with a one-cycle load and blinks the selected field.
module clock_set_ctrl
    import clock_pkg::*;
#(
    parameter int F_CLK     = 50000000,
    parameter int BLINK_HZ  = 2,
    parameter int HOLD_MS   = 500,
    parameter int REPEAT_MS = 100,
    parameter int TIMEOUT_S = 10
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [3:0] i_key,
    input  logic [4:0] i_hh,
    input  logic [5:0] i_mm,
    input  logic [5:0] i_ss,
    output logic       o_run,
    output logic       o_load,
    output logic [4:0] o_hh,
    output logic [5:0] o_mm,
    output logic [5:0] o_ss,
    output logic       o_edit,
    output logic [1:0] o_field,
    output logic [7:0] o_blink_mask
);

    localparam int BLINK_HALF  = F_CLK / (2 * BLINK_HZ);
    localparam int TIMEOUT_CYC = TIMEOUT_S * F_CLK;
    localparam int BLINK_W     = $clog2(BLINK_HALF + 1);
    localparam int TO_W        = $clog2(TIMEOUT_CYC + 1);

    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_HALF - 1);
    localparam logic [BLINK_W-1:0] BLINK_ONE  = BLINK_W'(1);
    localparam logic [TO_W-1:0]    TO_LAST    = TO_W'(TIMEOUT_CYC - 1);
    localparam logic [TO_W-1:0]    TO_ONE     = TO_W'(1);
    localparam logic [5:0]         HH_LIM     = 6'(HH_MAX);
    localparam logic [5:0]         MS_LIM     = 6'(MS_MAX);

    state_t             state_q;
    state_t             state_d;
    logic [4:0]         hh_q, hh_d;
    logic [5:0]         mm_q, mm_d;
    logic [5:0]         ss_q, ss_d;
    logic               mode_prev, next_prev;
    logic               mode_edge, next_edge;
    logic               up_step, dn_step;
    logic               inc, dec;
    logic               in_set, activity, timeout_hit;
    logic [BLINK_W-1:0] blink_cnt;
    logic               blink_phase;
    logic [TO_W-1:0]    to_cnt;

    function automatic logic [5:0] wrap_step(input logic [5:0] v, input logic [5:0] vmax,
                                             input logic up);
        if (up)
            return (v >= vmax) ? 6'd0 : v + 6'd1;
        else
            return (v == 6'd0) ? vmax : v - 6'd1;
    endfunction

    function automatic field_t state_field(input state_t s);
        case (s)
            SET_HH:  return FIELD_HH;
            SET_MM:  return FIELD_MM;
            SET_SS:  return FIELD_SS;
            default: return FIELD_NONE;
        endcase
    endfunction

    key_repeat #(.F_CLK(F_CLK), .HOLD_MS(HOLD_MS), .REPEAT_MS(REPEAT_MS)) u_up (
        .clk   (i_clk),
        .rst_n (i_rst_n),
        .key   (i_key[KEY_UP]),
        .step  (up_step)
    );

    key_repeat #(.F_CLK(F_CLK), .HOLD_MS(HOLD_MS), .REPEAT_MS(REPEAT_MS)) u_down (
        .clk   (i_clk),
        .rst_n (i_rst_n),
        .key   (i_key[KEY_DOWN]),
        .step  (dn_step)
    );

    assign mode_edge   = i_key[KEY_MODE] & ~mode_prev;
    assign next_edge   = i_key[KEY_NEXT] & ~next_prev;
    // Simultaneous UP and DOWN steps cancel but still count as activity
    assign inc         = up_step & ~dn_step;
    assign dec         = dn_step & ~up_step;
    assign in_set      = (state_q == SET_HH) || (state_q == SET_MM) || (state_q == SET_SS);
    assign activity    = mode_edge | next_edge | up_step | dn_step;
    assign timeout_hit = in_set & ~activity & (to_cnt == TO_LAST);

    assign o_hh = hh_q;
    assign o_mm = mm_q;
    assign o_ss = ss_q;

    always_comb begin
        state_d = state_q;
        hh_d    = hh_q;
        mm_d    = mm_q;
        ss_d    = ss_q;
        unique case (state_q)
            RUN: begin
                if (mode_edge) begin
                    state_d = SET_HH;
                    hh_d    = i_hh;
                    mm_d    = i_mm;
                    ss_d    = i_ss;
                end
            end
            SET_HH, SET_MM, SET_SS: begin
                if (mode_edge) begin
                    state_d = COMMIT;
                end else if (next_edge) begin
                    case (state_q)
                        SET_HH:  state_d = SET_MM;
                        SET_MM:  state_d = SET_SS;
                        default: state_d = SET_HH;
                    endcase
                end else if (inc | dec) begin
                    case (state_q)
                        SET_HH:  hh_d = 5'(wrap_step({1'b0, hh_q}, HH_LIM, inc));
                        SET_MM:  mm_d = wrap_step(mm_q, MS_LIM, inc);
                        default: ss_d = wrap_step(ss_q, MS_LIM, inc);
                    endcase
                end else if (timeout_hit) begin
                    state_d = RUN;
                end
            end
            COMMIT:  state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    // Display-side outputs are derived from the current state, so they trail it by a cycle
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= RUN;
            hh_q         <= '0;
            mm_q         <= '0;
            ss_q         <= '0;
            mode_prev    <= 1'b0;
            next_prev    <= 1'b0;
            blink_cnt    <= '0;
            blink_phase  <= 1'b0;
            to_cnt       <= '0;
            o_run        <= 1'b1;
            o_load       <= 1'b0;
            o_edit       <= 1'b0;
            o_field      <= FIELD_NONE;
            o_blink_mask <= '0;
        end else begin
            state_q      <= state_d;
            hh_q         <= hh_d;
            mm_q         <= mm_d;
            ss_q         <= ss_d;
            mode_prev    <= i_key[KEY_MODE];
            next_prev    <= i_key[KEY_NEXT];
            o_run        <= (state_d == RUN);
            o_load       <= (state_d == COMMIT);
            o_edit       <= in_set;
            o_field      <= in_set ? state_field(state_q) : FIELD_NONE;
            o_blink_mask <= (in_set && blink_phase) ? field_mask(state_field(state_q)) : '0;

            if (!in_set || next_edge || up_step || dn_step) begin
                blink_cnt   <= '0;
                blink_phase <= 1'b0;
            end else if (blink_cnt == BLINK_LAST) begin
                blink_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                blink_cnt <= blink_cnt + BLINK_ONE;
            end

            if (!in_set || activity)
                to_cnt <= '0;
            else
                to_cnt <= to_cnt + TO_ONE;
        end
    end

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Bench for clock_set_ctrl: timestamp-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized key traffic.
module tb_clock_set_ctrl;

    localparam int F_CLK     = 1000;
    localparam int BLINK_HZ  = 2;
    localparam int HOLD_MS   = 500;
    localparam int REPEAT_MS = 100;
    localparam int TIMEOUT_S = 4;

    localparam int HOLD_C = HOLD_MS * F_CLK / 1000;
    localparam int REP_C  = REPEAT_MS * F_CLK / 1000;
    localparam int BHALF  = F_CLK / (2 * BLINK_HZ);
    localparam int TO_C   = TIMEOUT_S * F_CLK;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] key = 4'd0;
    logic [4:0] i_hh = 5'd0;
    logic [5:0] i_mm = 6'd0;
    logic [5:0] i_ss = 6'd0;
    logic       o_run, o_load, o_edit;
    logic [4:0] o_hh;
    logic [5:0] o_mm, o_ss;
    logic [1:0] o_field;
    logic [7:0] o_blink_mask;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    clock_set_ctrl #(
        .F_CLK(F_CLK), .BLINK_HZ(BLINK_HZ), .HOLD_MS(HOLD_MS),
        .REPEAT_MS(REPEAT_MS), .TIMEOUT_S(TIMEOUT_S)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_key(key),
        .i_hh(i_hh), .i_mm(i_mm), .i_ss(i_ss),
        .o_run(o_run), .o_load(o_load),
        .o_hh(o_hh), .o_mm(o_mm), .o_ss(o_ss),
        .o_edit(o_edit), .o_field(o_field), .o_blink_mask(o_blink_mask)
    );

    always #5 clk = ~clk;

    // Reference model: mode 0=running, 1..3=editing field 0..2, 4=committing
    int m_st = 0;
    int m_ed[3] = '{0, 0, 0};
    int m_max[3] = '{23, 59, 59};
    int m_age[4] = '{0, 0, 0, 0};
    bit [3:0] m_pk = 4'd0;
    int m_cyc = 0, m_bstart = 0, m_last = 0;
    int e_run = 1, e_load = 0, e_hh = 0, e_mm = 0, e_ss = 0;
    int e_edit = 0, e_field = 3, e_mask = 0;

    function automatic bit rep_step(input bit lvl, input int age);
        return lvl && (age == 0 || (age >= HOLD_C && (age - HOLD_C) % REP_C == 0));
    endfunction

    task automatic model_reset();
        m_st = 0; m_ed = '{0, 0, 0}; m_pk = 4'd0; m_age = '{0, 0, 0, 0};
        m_cyc = 0; m_bstart = 0; m_last = 0;
        e_run = 1; e_load = 0; e_hh = 0; e_mm = 0; e_ss = 0;
        e_edit = 0; e_field = 3; e_mask = 0;
    endtask

    task automatic model_step();
        bit [3:0] k;
        bit me, ne, us, ds, act;
        int nst, f, ph;
        k = key;
        for (int j = 2; j < 4; j++)
            if (k[j]) m_age[j] = m_pk[j] ? m_age[j] + 1 : 0;
        me  = k[0] && !m_pk[0];
        ne  = k[1] && !m_pk[1];
        us  = rep_step(k[2], m_age[2]);
        ds  = rep_step(k[3], m_age[3]);
        act = me || ne || us || ds;
        ph  = ((m_cyc - m_bstart) / BHALF) % 2;
        if (m_st >= 1 && m_st <= 3) begin
            f = m_st - 1;
            e_edit = 1; e_field = f; e_mask = (ph == 1) ? (3 << (3 * f)) : 0;
        end else begin
            e_edit = 0; e_field = 3; e_mask = 0;
        end
        nst = m_st;
        case (m_st)
            0: if (me) begin
                m_ed[0] = int'(i_hh); m_ed[1] = int'(i_mm); m_ed[2] = int'(i_ss);
                nst = 1; m_bstart = m_cyc + 1; m_last = m_cyc;
            end
            1, 2, 3: begin
                f = m_st - 1;
                if (me) nst = 4;
                else if (ne) nst = (m_st == 3) ? 1 : m_st + 1;
                else if (us && !ds) m_ed[f] = (m_ed[f] + 1) % (m_max[f] + 1);
                else if (ds && !us) m_ed[f] = (m_ed[f] + m_max[f]) % (m_max[f] + 1);
                if (ne || us || ds) m_bstart = m_cyc + 1;
                if (act) m_last = m_cyc;
                else if (m_cyc - m_last >= TO_C) nst = 0;
            end
            default: nst = 0;
        endcase
        m_st = nst;
        e_run = (nst == 0) ? 1 : 0;
        e_load = (nst == 4) ? 1 : 0;
        e_hh = m_ed[0]; e_mm = m_ed[1]; e_ss = m_ed[2];
        m_pk = k;
        m_cyc++;
    endtask

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) model_reset();
        else model_step();
    end

    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            tests++;
            if (int'(o_run) != e_run || int'(o_load) != e_load || int'(o_hh) != e_hh ||
                int'(o_mm) != e_mm || int'(o_ss) != e_ss || int'(o_edit) != e_edit ||
                int'(o_field) != e_field || int'(o_blink_mask) != e_mask) begin
                fails++;
                $display("FAIL cycle_cmp t=%0t got run%0d load%0d %0d:%0d:%0d edit%0d fld%0d mask%0h, required run%0d load%0d %0d:%0d:%0d edit%0d fld%0d mask%0h",
                         $time, o_run, o_load, o_hh, o_mm, o_ss, o_edit, o_field, o_blink_mask,
                         e_run, e_load, e_hh, e_mm, e_ss, e_edit, e_field, e_mask);
            end
        end
    end

    task automatic check(input string name, input int act, input int req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input logic [3:0] k, input int n);
        key = k;
        tick(n);
        key = 4'd0;
        tick(3);
    endtask

    int loads, lh, lm, ls, run_after, idx, mask_on, mask_bad, h0;

    initial begin
        // Reset state
        tick(3);
        check("rst_run", int'(o_run), 1);
        check("rst_load", int'(o_load), 0);
        check("rst_field", int'(o_field), 3);
        check("rst_mask", int'(o_blink_mask), 0);
        rst_n = 1'b1;
        chk_en = 1'b1;
        tick(2);

        // Enter edit, wrap hours up and down
        i_hh = 5'd12; i_mm = 6'd34; i_ss = 6'd56;
        press(4'b0001, 1);
        check("enter_edit", int'(o_edit), 1);
        check("enter_field", int'(o_field), 0);
        check("enter_hh", int'(o_hh), 12);
        check("enter_run", int'(o_run), 0);
        repeat (12) press(4'b0100, 1);
        check("hh_wrap_up", int'(o_hh), 0);
        press(4'b1000, 1);
        check("hh_wrap_down", int'(o_hh), 23);
        press(4'b0001, 1);
        check("commit_run", int'(o_run), 1);

        // Minute/second wrap and a single load strobe
        i_hh = 5'd12; i_mm = 6'd0; i_ss = 6'd59;
        press(4'b0001, 1);
        press(4'b0010, 1);
        press(4'b1000, 1);
        press(4'b0010, 1);
        press(4'b0100, 1);
        key = 4'b0001;
        loads = 0; lh = -1; lm = -1; ls = -1; run_after = -1; idx = 100;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i == idx + 1) run_after = int'(o_run);
            if (o_load) begin
                loads++; lh = int'(o_hh); lm = int'(o_mm); ls = int'(o_ss); idx = i;
            end
        end
        key = 4'd0;
        tick(3);
        check("load_count", loads, 1);
        check("load_hh", lh, 12);
        check("load_mm", lm, 59);
        check("load_ss", ls, 0);
        check("run_after_load", run_after, 1);

        // Auto-repeat while holding UP in minutes
        i_mm = 6'd10;
        press(4'b0001, 1);
        press(4'b0010, 1);
        check("mm_start", int'(o_mm), 10);
        key = 4'b0100;
        tick(HOLD_C + 2 * REP_C + 60);
        key = 4'd0;
        tick(3);
        check("mm_repeat", int'(o_mm), 14);
        press(4'b0001, 1);

        // Inactivity abort from seconds field
        press(4'b0001, 1);
        press(4'b0010, 1);
        press(4'b0010, 1);
        check("ss_field", int'(o_field), 2);
        loads = 0;
        for (int i = 0; i < TO_C + 10; i++) begin
            @(negedge clk);
            if (o_load) loads++;
        end
        check("timeout_noload", loads, 0);
        check("timeout_run", int'(o_run), 1);
        check("timeout_field", int'(o_field), 3);

        // Blink duty, cancelling steps, MODE priority
        press(4'b0001, 1);
        mask_on = 0; mask_bad = 0;
        for (int i = 0; i < 4 * BHALF; i++) begin
            @(negedge clk);
            if (o_blink_mask == 8'b0000_0011) mask_on++;
            else if (o_blink_mask != 8'd0) mask_bad++;
        end
        check("blink_on_cycles", mask_on, 2 * BHALF);
        check("blink_bad_cycles", mask_bad, 0);
        h0 = int'(o_hh);
        press(4'b1100, 1);
        check("updown_cancel", int'(o_hh), h0);
        key = 4'b0101;
        loads = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (o_load) loads++;
        end
        key = 4'd0;
        tick(3);
        check("mode_up_load", loads, 1);
        check("mode_up_hh", int'(o_hh), h0);
        check("mode_up_run", int'(o_run), 1);

        // Asynchronous reset in the middle of an edit
        press(4'b0001, 1);
        press(4'b0010, 1);
        check("pre_rst_field", int'(o_field), 1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_run", int'(o_run), 1);
        check("arst_load", int'(o_load), 0);
        check("arst_field", int'(o_field), 3);
        check("arst_edit", int'(o_edit), 0);
        check("arst_hh", int'(o_hh), 0);
        loads = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (i == 3) rst_n = 1'b1;
            if (o_load) loads++;
        end
        check("arst_noload", loads, 0);

        // Randomized key traffic
        for (int it = 0; it < 300; it++) begin
            int r, hold;
            logic [3:0] k;
            i_hh = 5'($urandom_range(0, 23));
            i_mm = 6'($urandom_range(0, 59));
            i_ss = 6'($urandom_range(0, 59));
            r = $urandom_range(0, 15);
            if (r < 3) k = 4'b0001;
            else if (r < 6) k = 4'($urandom_range(1, 15));
            else k = 4'(1 << $urandom_range(1, 3));
            hold = ($urandom_range(0, 9) == 0) ? $urandom_range(HOLD_C - 100, HOLD_C + 3 * REP_C)
                                               : $urandom_range(1, 4);
            key = k;
            tick(hold);
            key = 4'd0;
            tick($urandom_range(1, 4));
            if (it % 100 == 99) tick(TO_C + 100);
        end

        tick(5);
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/clock_set_ctrl.md
Name: clock_set_ctrl

Overview:
Key-driven time-setting controller for the digital clock.
- Freezes the hh/mm/ss timekeeper and captures its current time into edit registers.
- Lets the user select a field and step it up or down, with auto-repeat while a key is held.
- Writes the edited time back with a one-cycle load pulse.
- Drives a per-digit blink mask to the 8-digit display scanner. Sits between the debounced key inputs and the timekeeper/display mux.

Parameters:
- F_CLK, 50000000, input clock frequency in Hz; must be ≥1000 and a multiple of 1000.
- BLINK_HZ, 2, blink rate of the selected field.
- HOLD_MS, 500, UP/DOWN hold time before auto-repeat starts.
- REPEAT_MS, 100, auto-repeat step period.
- TIMEOUT_S, 10, inactivity time in SET states before abort.

Ports:
- i_clk  in  1  system clock
- i_rst_n  in  1  asynchronous active-low reset
- i_key  in  4  debounced key levels, active high: [0]=MODE, [1]=NEXT, [2]=UP, [3]=DOWN
- i_hh  in  5  timekeeper hours, 0..23
- i_mm  in  6  timekeeper minutes, 0..59
- i_ss  in  6  timekeeper seconds, 0..59
- o_run  out  1  timekeeper count enable
- o_load  out  1  single-cycle load strobe to timekeeper
- o_hh  out  5  edit hours (load value; display source when o_edit=1)
- o_mm  out  6  edit minutes
- o_ss  out  6  edit seconds
- o_edit  out  1  high in SET_HH, SET_MM, SET_SS; selects edit regs for display
- o_field  out  2  0=HH, 1=MM, 2=SS, 3=none (RUN, COMMIT)
- o_blink_mask  out  8  1 = blank digit; digits 0-1 hh, 3-4 mm, 6-7 ss, 2 and 5 separators

Behaviour:
- Reset (async, any time, including mid-edit):
  - state=RUN, o_run=1, o_load=0.
  - o_hh/o_mm/o_ss=0, o_edit=0, o_field=3, o_blink_mask=0, all counters 0.
  - Nothing is loaded.
- MODE and NEXT act on their rising edges only (registered previous level).
- UP/DOWN stepping:
  - One step on the rising edge.
  - While held, a further step once HOLD_MS·F_CLK/1000 cycles have elapsed since the edge, then one every REPEAT_MS·F_CLK/1000 cycles.
  - Release resets the hold counter.
- States:
  - RUN: o_run=1. MODE edge → latch i_hh/i_mm/i_ss into edit regs in that cycle, go SET_HH; o_run=0 from the next cycle.
  - SET_HH / SET_MM / SET_SS:
    - UP step: field+1, with wrap 23→0 for hh and 59→0 for mm/ss.
    - DOWN step: field−1, with wrap 0→23 or 0→59.
    - NEXT edge: HH→MM→SS→HH.
    - MODE edge: → COMMIT.
  - COMMIT: o_load=1 for exactly this one cycle with the edit values on o_hh/o_mm/o_ss; o_run=0. Next state RUN.
- Priority when events coincide in one cycle: MODE > NEXT > UP/DOWN.
  - UP and DOWN steps in the same cycle cancel; no change.
- Timeout:
  - Counter of TIMEOUT_S·F_CLK cycles, cleared on any key edge or repeat step.
  - On expiry in a SET state → RUN with no load; the timekeeper resumes from its frozen value.
- Blink:
  - Phase flips every F_CLK/(2·BLINK_HZ) cycles while o_edit=1.
  - When phase=1, the two digits of the selected field are masked.
  - Any step or NEXT forces phase=0 and restarts the blink counter.
  - Mask is 0 outside SET states.
- Outputs are registered. o_field/o_edit/o_blink_mask change in the cycle after the state changes.

Decomposition:
- Package clock_pkg holds:
  - state enum {RUN, SET_HH, SET_MM, SET_SS, COMMIT} and field enum.
  - Key index constants KEY_MODE/NEXT/UP/DOWN.
  - HH_MAX=23, MS_MAX=59.
  - Digit index constants for the hh/mm/ss digit pairs.
- Sub-module key_repeat (edge detect + hold/repeat counters, parameters F_CLK, HOLD_MS, REPEAT_MS, output step pulse) is instantiated for UP and for DOWN.

Test Plan:
All scenarios use F_CLK=10000, so HOLD=5000 cycles, REPEAT=1000 cycles, blink half-period=2500 cycles, timeout=100000 cycles.
1. Hold i_rst_n=0, then release → o_run=1, o_load=0, o_field=3, o_blink_mask=0. Assert reset while in SET_MM → returns to RUN immediately, o_load never pulses.
2. i_hh=12,i_mm=34,i_ss=56; pulse MODE → o_edit=1, o_field=0, o_hh=12, o_run=0. UP ×12 (separate presses) → o_hh=0 (wrap). DOWN ×1 → o_hh=23.
3. MODE; NEXT; DOWN from mm=0; NEXT; UP from ss=59; MODE → mm=59, ss=0; exactly one o_load cycle with o_hh/o_mm/o_ss=12/59/0; RUN and o_run=1 the next cycle.
4. In SET_MM with mm=10, hold UP for 7600 cycles → steps at edge, +5000, +6000, +7000 → mm=14.
5. In SET_SS, no keys for 100000 cycles → RUN, o_load never asserted, o_run=1.
6. In SET_HH, blink: o_blink_mask=8'b0000_0011 during alternate 2500-cycle windows. UP and DOWN rising in the same cycle → value unchanged. MODE and UP in the same cycle → COMMIT, value unchanged.
